// File: rtl/snes_pkg.sv
// Shared definitions for the SNES controller link: poller FSM states and the
// button bit order used by both the poller and the encoder.
package snes_pkg;

    localparam int NBITS = 16;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;
    localparam int ID_LSB     = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SETTLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } snes_poll_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit; resets to 0.
module sync_2ff (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/snes_poller.sv
// Console-side SNES pad reader: drives latch and 16 clock pulses each poll period,
// shifts in the active-low serial data and publishes an active-high button word.
module snes_poller
    import snes_pkg::*;
#(
    parameter int HALF_CYC  = 12,
    parameter int LATCH_CYC = 25,
    parameter int POLL_CYC  = 34667
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             poll_en,
    input  logic             ser_data,
    output logic             snes_clk,
    output logic             snes_latch,
    output logic [NBITS-1:0] buttons,
    output logic             valid,
    output logic             present
);

    localparam int MAX_PHASE = (HALF_CYC > LATCH_CYC) ? HALF_CYC : LATCH_CYC;
    localparam int CW        = $clog2(MAX_PHASE);
    localparam int TW        = $clog2(POLL_CYC);

    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYC - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYC - 1);
    localparam logic [TW-1:0] POLL_LAST  = TW'(POLL_CYC - 1);
    localparam logic [4:0]    LAST_PULSE = 5'(NBITS);

    snes_poll_state_t state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [4:0]       pulse_q, pulse_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic             snes_clk_q, snes_clk_d;
    logic             snes_latch_q, snes_latch_d;
    logic [NBITS-1:0] buttons_q, buttons_d;
    logic             valid_q, valid_d;
    logic             present_q, present_d;
    logic             tick;
    logic             ser_sync;

    sync_2ff u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (ser_data),
        .q       (ser_sync)
    );

    assign tick    = (timer_q == POLL_LAST);
    assign timer_d = tick ? '0 : timer_q + TW'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            cnt_q        <= '0;
            pulse_q      <= '0;
            shift_q      <= '0;
            snes_clk_q   <= 1'b1;
            snes_latch_q <= 1'b0;
            buttons_q    <= '0;
            valid_q      <= 1'b0;
            present_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cnt_q        <= cnt_d;
            pulse_q      <= pulse_d;
            shift_q      <= shift_d;
            snes_clk_q   <= snes_clk_d;
            snes_latch_q <= snes_latch_d;
            buttons_q    <= buttons_d;
            valid_q      <= valid_d;
            present_q    <= present_d;
        end
    end

    // Bits arrive LSB first; shifting in at the MSB leaves sample 0 in bit 0 after 16 samples.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        pulse_d = pulse_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (tick && poll_en) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                    pulse_d = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == HALF_LAST) begin
                    shift_d = {ser_sync, shift_q[NBITS-1:1]};
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    pulse_d = pulse_q + 5'd1;
                end
            end
            ST_LOW: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_HIGH: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (pulse_q == LAST_PULSE) begin
                        state_d = ST_DONE;
                    end else begin
                        shift_d = {ser_sync, shift_q[NBITS-1:1]};
                        state_d = ST_LOW;
                        pulse_d = pulse_q + 5'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Link outputs follow the next state so they are registered alongside it.
    always_comb begin
        snes_latch_d = (state_d == ST_LATCH);
        snes_clk_d   = (state_d != ST_LOW);
        valid_d      = (state_q == ST_DONE);
        buttons_d    = valid_d ? ~shift_q : buttons_q;
        present_d    = valid_d ? (&shift_q[NBITS-1:ID_LSB]) : present_q;
    end

    assign snes_clk   = snes_clk_q;
    assign snes_latch = snes_latch_q;
    assign buttons    = buttons_q;
    assign valid      = valid_q;
    assign present    = present_q;

endmodule
